mac_pipe: RTL and testbench
===========================

# mac_pipe

Parametrised, fully pipelined unsigned multiply-add / multiply-accumulate unit, the next generation of the team's fixed three-stage A*B+C datapath. Per-sample valid qualification, two operating modes (single multiply-add, or framed accumulation of products with saturation), overflow flag and per-frame sample count. Sits between operand sources and downstream result consumers; accepts one sample per clock with no backpressure.

## Interface
- S, 8, operand width (A, B, C), S >= 2
- G, 4, accumulator guard bits, G >= 1; result width W = 2*S+G
- CNT_W, 8, width of per-frame sample counter
- clk  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge while high
- in_valid  input  1  A/B/C/in_mode/in_last are valid this cycle
- A  input  S  multiplicand, unsigned
- B  input  S  multiplier, unsigned
- C  input  S  addend, used in mode 0 only
- in_mode  input  1  0 = multiply-add (A*B+C), 1 = accumulate (acc += A*B)
- in_last  input  1  mode 1 only: sample closes the current frame
- out_valid  output  1  single-cycle strobe, DATA_OUT/ovf/cnt valid
- DATA_OUT  output  W  result, zero-extended
- ovf  output  1  accumulation saturated somewhere in the reported frame
- cnt  output  CNT_W  mode 1: number of samples in reported frame (saturating); mode 0: 1
- ch1  output  2*S  debug tap: stage-2 product register
- ch2  output  W  debug tap: running accumulator register

## Operation
- Stage 1: when in_valid=1, register A, B, C, in_mode, in_last; v1 <= in_valid every cycle (bubbles propagate, operand registers hold when in_valid=0).
- Stage 2: prod <= a1*b1 (2*S bits, exact); carry c1, mode, last forward; v2 <= v1.
- Stage 3, acts only when v2=1:
  - mode 0: DATA_OUT <= prod + c2 (cannot overflow since G >= 1), ovf <= 0, cnt <= 1, out_valid <= 1. Accumulator, its ovf, and its counter untouched.
  - mode 1, last=0: acc <= sat(acc + prod); acc_ovf |= overflow; acc_cnt <= sat(acc_cnt+1); out_valid <= 0.
  - mode 1, last=1: DATA_OUT <= sat(acc + prod), ovf <= acc_ovf | overflow, cnt <= sat(acc_cnt+1), out_valid <= 1; acc, acc_ovf, acc_cnt <= 0 (next frame starts clean).
- sat(x): if x > 2^W-1 then 2^W-1 and overflow=1; once saturated the accumulator stays at 2^W-1 until frame end.
- Counter saturates at 2^CNT_W-1, never wraps.
- Interleaved mode 0 samples inside an open mode-1 frame are legal; they produce their own result and do not disturb the frame.
- A mode 1 frame with no last stays open indefinitely.
- When v2=0: out_valid <= 0, DATA_OUT/ovf/cnt hold last value.

## Timing
- Latency: sample with in_valid=1 in cycle k -> out_valid=1 in cycle k+3 (mode 0, or mode 1 with in_last=1).
- Throughput 1 sample/clock, back-to-back samples give back-to-back results; no handshake/backpressure.
- Reset values: out_valid=0, DATA_OUT=0, ovf=0, cnt=0, ch1=0, ch2=0; all pipeline valids, accumulator, acc_ovf, acc_cnt = 0.
- Reset mid-operation: all in-flight samples and any open frame discarded; no out_valid for them. Sample presented in the cycle reset deasserts (reset=0) is accepted normally.
- reset and in_valid high together: reset wins, sample dropped.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> all outputs 0, no out_valid in following 3 cycles.
- Mode 0, S=8: A=3,B=4,C=5 cycle k -> out_valid at k+3, DATA_OUT=17, cnt=1, ovf=0; then A=B=C=255 back-to-back -> DATA_OUT=65280 next cycle.
- Mode 1 frame: four samples A=B=10, last on the fourth, in_valid gaps between them -> one out_valid, DATA_OUT=400, cnt=4, ovf=0; ch2 returns to 0 after.
- Saturation, S=8,G=4: 16 samples A=B=255 last on 16th -> DATA_OUT=1040400, ovf=0; 17 samples -> DATA_OUT=1048575, ovf=1; next frame of one sample 2*2 -> DATA_OUT=4, ovf=0.
- Interleave: open mode-1 frame (5*5), mode 0 sample (1*1+1), then mode-1 last (5*5) -> results 2 (cnt=1) then 50 (cnt=2) in order.
- Reset mid-frame: two mode-1 samples 7*7, reset 1 cycle, then one sample 2*3 with last -> DATA_OUT=6, cnt=1.

Source files
------------

// File: rtl/mac_pipe_if.sv
// mac_pipe_if: bundles the sample-input and result-output signals of mac_pipe.
//   master modport : operand source / result consumer side (testbench, upstream logic)
//   slave modport  : the mac_pipe datapath itself
// Signals:
//   in_valid, A, B, C, in_mode, in_last : sample input (A/B/C are S bits, unsigned)
//   out_valid, DATA_OUT, ovf, cnt        : result strobe, W-bit result, saturation flag, frame count
//   ch1, ch2                             : debug taps (product register, running accumulator)
interface mac_pipe_if #(
  parameter int S     = 8,
  parameter int G     = 4,
  parameter int CNT_W = 8
);
  localparam int W = 2*S + G;

  logic             in_valid;
  logic [S-1:0]     A;
  logic [S-1:0]     B;
  logic [S-1:0]     C;
  logic             in_mode;
  logic             in_last;
  logic             out_valid;
  logic [W-1:0]     DATA_OUT;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic [2*S-1:0]   ch1;
  logic [W-1:0]     ch2;

  modport master (
    output in_valid, A, B, C, in_mode, in_last,
    input  out_valid, DATA_OUT, ovf, cnt, ch1, ch2
  );

  modport slave (
    input  in_valid, A, B, C, in_mode, in_last,
    output out_valid, DATA_OUT, ovf, cnt, ch1, ch2
  );
endinterface

// File: rtl/mac_pipe.sv
// mac_pipe: three-stage unsigned multiply-add / framed multiply-accumulate unit.
//   mode 0 : DATA_OUT = A*B + C, one result per sample
//   mode 1 : products are accumulated (saturating at 2^W-1) until a sample with
//            in_last closes the frame; the frame total, overflow flag and sample
//            count are then reported and the accumulator restarts from zero.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears every register
//   bus   : mac_pipe_if slave modport (sample inputs, result outputs, debug taps)
// Latency is three clocks, throughput one sample per clock, no backpressure.
module mac_pipe #(
  parameter int S     = 8,
  parameter int G     = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  mac_pipe_if.slave    bus
);
  localparam int W = 2*S + G;

  logic             r_v1;
  logic [S-1:0]     r_a1;
  logic [S-1:0]     r_b1;
  logic [S-1:0]     r_c1;
  logic             r_mode1;
  logic             r_last1;

  logic             r_v2;
  logic [2*S-1:0]   r_prod;
  logic [S-1:0]     r_c2;
  logic             r_mode2;
  logic             r_last2;

  logic [W-1:0]     r_acc;
  logic             r_accOvf;
  logic [CNT_W-1:0] r_accCnt;

  logic             r_outValid;
  logic [W-1:0]     r_dataOut;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [2*S-1:0]   w_prod;
  logic [W:0]       w_accSum;
  logic             w_accOverflow;
  logic [W-1:0]     w_accSat;
  logic [W-1:0]     w_maddSum;
  logic [CNT_W-1:0] w_cntInc;

  // Stage 1: capture operands only for valid samples; the valid bit itself
  // is registered every cycle so bubbles travel down the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_a1    <= '0;
      r_b1    <= '0;
      r_c1    <= '0;
      r_mode1 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_a1    <= bus.A;
        r_b1    <= bus.B;
        r_c1    <= bus.C;
        r_mode1 <= bus.in_mode;
        r_last1 <= bus.in_last;
      end
    end
  end

  // Operands are zero-extended so the product is computed at its full 2*S width.
  assign w_prod = {{S{1'b0}}, r_a1} * {{S{1'b0}}, r_b1};

  // Stage 2: exact product plus forwarded sideband.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2    <= 1'b0;
      r_prod  <= '0;
      r_c2    <= '0;
      r_mode2 <= 1'b0;
      r_last2 <= 1'b0;
    end else begin
      r_v2    <= r_v1;
      r_prod  <= w_prod;
      r_c2    <= r_c1;
      r_mode2 <= r_mode1;
      r_last2 <= r_last1;
    end
  end

  // The accumulator sum carries one extra bit; that bit is the overflow.
  // A saturated accumulator re-saturates on every further non-zero product,
  // so it stays pinned at all-ones until the frame closes.
  assign w_accSum      = {1'b0, r_acc} + {{(G+1){1'b0}}, r_prod};
  assign w_accOverflow = w_accSum[W];
  assign w_accSat      = w_accOverflow ? {W{1'b1}} : w_accSum[W-1:0];
  assign w_maddSum     = {{G{1'b0}}, r_prod} + {{(W-S){1'b0}}, r_c2};
  assign w_cntInc      = (&r_accCnt) ? r_accCnt : r_accCnt + CNT_W'(1);

  // Stage 3: mode 0 reports immediately and leaves the frame state alone, so
  // multiply-add samples may be interleaved inside an open accumulation frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_accOvf   <= 1'b0;
      r_accCnt   <= '0;
      r_outValid <= 1'b0;
      r_dataOut  <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_outValid <= 1'b0;
      if (r_v2) begin
        if (!r_mode2) begin
          r_dataOut  <= w_maddSum;
          r_ovf      <= 1'b0;
          r_cnt      <= CNT_W'(1);
          r_outValid <= 1'b1;
        end else if (!r_last2) begin
          r_acc    <= w_accSat;
          r_accOvf <= r_accOvf | w_accOverflow;
          r_accCnt <= w_cntInc;
        end else begin
          r_dataOut  <= w_accSat;
          r_ovf      <= r_accOvf | w_accOverflow;
          r_cnt      <= w_cntInc;
          r_outValid <= 1'b1;
          r_acc      <= '0;
          r_accOvf   <= 1'b0;
          r_accCnt   <= '0;
        end
      end
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.DATA_OUT  = r_dataOut;
  assign bus.ovf       = r_ovf;
  assign bus.cnt       = r_cnt;
  assign bus.ch1       = r_prod;
  assign bus.ch2       = r_acc;
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: self-checking bench for mac_pipe.
// A behavioural model predicts each result when its sample is accepted and
// queues it with the accepting clock edge; a negedge monitor pairs every
// out_valid with the queue head and checks value, flags and latency.
module tb_mac_pipe;
  localparam int S     = 8;
  localparam int G     = 4;
  localparam int CNT_W = 8;
  localparam int W     = 2*S + G;
  localparam longint MAXW = (longint'(1) << W) - 1;
  localparam int     MAXC = (1 << CNT_W) - 1;

  typedef struct {
    longint data;
    bit     ovf;
    int     cnt;
    int     acceptEdge;
  } expT;

  logic clk;
  logic reset;
  int   totalChecks = 0;
  int   badChecks   = 0;
  int   edgeCount   = 0;
  expT  expQ[$];

  longint modelAcc    = 0;
  bit     modelAccOvf = 0;
  int     modelAccCnt = 0;

  mac_pipe_if #(.S(S), .G(G), .CNT_W(CNT_W)) bus();

  mac_pipe #(.S(S), .G(G), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so results can be tied to their accepting edge.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the model
  // with what the DUT must have accepted on that edge.
  task automatic applyStimulus(input bit rst, input bit v, input logic [S-1:0] a,
                               input logic [S-1:0] b, input logic [S-1:0] c,
                               input bit m, input bit l);
    expT    e;
    longint sum;
    bit     o;
    reset        = rst;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.C        = c;
    bus.in_mode  = m;
    bus.in_last  = l;
    @(posedge clk);
    #1;
    if (rst) begin
      expQ.delete();
      modelAcc    = 0;
      modelAccOvf = 0;
      modelAccCnt = 0;
    end else if (v) begin
      e.acceptEdge = edgeCount;
      if (!m) begin
        e.data = longint'(a) * longint'(b) + longint'(c);
        e.ovf  = 0;
        e.cnt  = 1;
        expQ.push_back(e);
      end else begin
        sum = modelAcc + longint'(a) * longint'(b);
        o   = sum > MAXW;
        if (o) sum = MAXW;
        if (l) begin
          e.data = sum;
          e.ovf  = modelAccOvf | o;
          e.cnt  = (modelAccCnt + 1 > MAXC) ? MAXC : modelAccCnt + 1;
          expQ.push_back(e);
          modelAcc    = 0;
          modelAccOvf = 0;
          modelAccCnt = 0;
        end else begin
          modelAcc    = sum;
          modelAccOvf = modelAccOvf | o;
          modelAccCnt = (modelAccCnt + 1 > MAXC) ? MAXC : modelAccCnt + 1;
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, 0);
  endtask

  // Result monitor: every strobe must match the queue head exactly two edges
  // after the sample's accepting edge; a due result with no strobe is a miss.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", 1, 0);
      end else begin
        checkOutput("latency", edgeCount, expQ[0].acceptEdge + 2);
        checkOutput("data", bus.DATA_OUT, expQ[0].data);
        checkOutput("ovf", bus.ovf, expQ[0].ovf);
        checkOutput("cnt", bus.cnt, expQ[0].cnt);
        void'(expQ.pop_front());
      end
    end else if (expQ.size() > 0 && expQ[0].acceptEdge + 2 <= edgeCount) begin
      checkOutput("missingValid", bus.out_valid, 1);
      void'(expQ.pop_front());
    end
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.C        = '0;
    bus.in_mode  = 1'b0;
    bus.in_last  = 1'b0;

    // Reset held two cycles with a valid sample present: nothing may emerge.
    applyStimulus(1, 1, 8'd9, 8'd9, 8'd9, 0, 0);
    applyStimulus(1, 1, 8'd9, 8'd9, 8'd9, 1, 1);
    checkOutput("rstValid", bus.out_valid, 0);
    checkOutput("rstData", bus.DATA_OUT, 0);
    checkOutput("rstOvf", bus.ovf, 0);
    checkOutput("rstCnt", bus.cnt, 0);
    checkOutput("rstCh1", bus.ch1, 0);
    checkOutput("rstCh2", bus.ch2, 0);
    idleCycles(3);

    // Mode 0 with explicit latency, then full-scale back-to-back samples.
    applyStimulus(0, 1, 8'd3, 8'd4, 8'd5, 0, 0);
    idleCycles(1);
    checkOutput("ch1Product", bus.ch1, 12);
    idleCycles(1);
    checkOutput("madValid", bus.out_valid, 1);
    checkOutput("madData", bus.DATA_OUT, 17);
    checkOutput("madCnt", bus.cnt, 1);
    applyStimulus(0, 1, 8'd255, 8'd255, 8'd255, 0, 0);
    applyStimulus(0, 1, 8'd255, 8'd255, 8'd255, 0, 0);
    idleCycles(3);
    checkOutput("madMax", bus.DATA_OUT, 65280);

    // Four-sample frame with gaps between samples.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 8'd10, 8'd10, 8'd0, 1, i == 3);
      idleCycles(1);
    end
    idleCycles(3);
    checkOutput("frameData", bus.DATA_OUT, 400);
    checkOutput("frameCnt", bus.cnt, 4);
    checkOutput("frameCh2Clear", bus.ch2, 0);

    // Saturation boundary: 16 full-scale products fit, 17 do not.
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'd255, 8'd255, 8'd0, 1, i == 15);
    idleCycles(3);
    checkOutput("fit16Data", bus.DATA_OUT, 1040400);
    checkOutput("fit16Ovf", bus.ovf, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 8'd255, 8'd255, 8'd0, 1, i == 16);
    idleCycles(3);
    checkOutput("sat17Data", bus.DATA_OUT, 1048575);
    checkOutput("sat17Ovf", bus.ovf, 1);
    applyStimulus(0, 1, 8'd2, 8'd2, 8'd0, 1, 1);
    idleCycles(3);
    checkOutput("cleanData", bus.DATA_OUT, 4);
    checkOutput("cleanOvf", bus.ovf, 0);

    // Mode 0 sample interleaved inside an open frame.
    applyStimulus(0, 1, 8'd5, 8'd5, 8'd0, 1, 0);
    applyStimulus(0, 1, 8'd1, 8'd1, 8'd1, 0, 0);
    applyStimulus(0, 1, 8'd5, 8'd5, 8'd0, 1, 1);
    idleCycles(3);
    checkOutput("ilvData", bus.DATA_OUT, 50);
    checkOutput("ilvCnt", bus.cnt, 2);

    // Reset in the middle of an open frame discards it.
    applyStimulus(0, 1, 8'd7, 8'd7, 8'd0, 1, 0);
    applyStimulus(0, 1, 8'd7, 8'd7, 8'd0, 1, 0);
    applyStimulus(1, 0, '0, '0, '0, 0, 0);
    applyStimulus(0, 1, 8'd2, 8'd3, 8'd0, 1, 1);
    idleCycles(3);
    checkOutput("rstFrameData", bus.DATA_OUT, 6);
    checkOutput("rstFrameCnt", bus.cnt, 1);

    // Sample counter saturates rather than wrapping.
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 8'd1, 8'd1, 8'd0, 1, i == 299);
    idleCycles(3);
    checkOutput("longData", bus.DATA_OUT, 300);
    checkOutput("longCntSat", bus.cnt, MAXC);

    // Randomised traffic: mixed modes, gaps, frame ends and rare resets.
    for (int i = 0; i < 600; i++) begin
      logic [S-1:0] ra, rb, rc;
      ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rc = 8'($urandom);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ra, rb, rc,
                    1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
    end

    idleCycles(5);
    checkOutput("drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
